// File: rtl/spi_accel_pkg.sv
// Shared constants and FSM encoding for the SPI accelerometer responder.
// Command bytes, register addresses and controller states.
package spi_accel_pkg;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
    localparam logic [7:0] ADDR_PARTID    = 8'h02;
    localparam logic [7:0] ADDR_XDATA     = 8'h08;
    localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA_RD,
        DATA_WR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer with rise/fall pulse detection.
// Ports: clk_in, nrst, din (async pin) -> rise, fall (one-cycle pulses).
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic nrst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    assign level = sync_q[STAGES-1];

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating the accelerometer command protocol.
// Ports: clk_in, nrst, spi_cs_n/sclk/mosi/miso, xdata_in, power_ctl,
//        wr_strobe/wr_addr/wr_data (write side), xdata_rd (X read pulse).
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       nrst,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] xdata_in,
    output logic [7:0] power_ctl,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       xdata_rd
);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_edge_sync #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b0)
    ) u_sclk_sync (
        .clk_in(clk_in),
        .nrst  (nrst),
        .din   (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_cs_sync (
        .clk_in(clk_in),
        .nrst  (nrst),
        .din   (spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as sclk so the sampled bit lines up with the rise pulse.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) mosi_q <= '0;
        else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    state_t     state_q, state_nx;
    logic [2:0] bit_cnt_q, bit_cnt_nx;
    logic [7:0] shift_q, shift_nx;
    logic [7:0] addr_q, addr_nx;
    logic [7:0] tx_q, tx_nx;
    logic       is_rd_q, is_rd_nx;
    logic [7:0] power_ctl_nx;
    logic       wr_strobe_nx;
    logic [7:0] wr_addr_nx, wr_data_nx;
    logic       xdata_rd_nx;

    logic [7:0] shift_in;
    logic [7:0] addr_inc;
    logic       byte_done;

    function automatic logic [7:0] rd_val(
        input logic [7:0] a,
        input logic [7:0] xd,
        input logic [7:0] pc
    );
        logic [7:0] v;
        unique case (a)
            ADDR_DEVID_AD:  v = DEVID_AD;
            ADDR_DEVID_MST: v = DEVID_MST;
            ADDR_PARTID:    v = PARTID;
            ADDR_XDATA:     v = xd;
            ADDR_POWER_CTL: v = pc;
            default:        v = 8'h00;
        endcase
        return v;
    endfunction

    assign shift_in  = {shift_q[6:0], mosi_s};
    assign addr_inc  = addr_q + 8'd1;
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_nx     = state_q;
        bit_cnt_nx   = bit_cnt_q;
        shift_nx     = shift_q;
        addr_nx      = addr_q;
        tx_nx        = tx_q;
        is_rd_nx     = is_rd_q;
        power_ctl_nx = power_ctl;
        wr_strobe_nx = 1'b0;
        wr_addr_nx   = wr_addr;
        wr_data_nx   = wr_data;
        xdata_rd_nx  = 1'b0;

        if (state_q != IDLE && sclk_rise) begin
            shift_nx   = shift_in;
            bit_cnt_nx = bit_cnt_q + 3'd1;
        end

        // Deselect wins over everything, including a completing byte.
        if (cs_rise) begin
            state_nx = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_nx   = CMD;
                        bit_cnt_nx = 3'd0;
                        shift_nx   = 8'h00;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        if (shift_in == CMD_READ) begin
                            state_nx = ADDR;
                            is_rd_nx = 1'b1;
                        end else if (shift_in == CMD_WRITE) begin
                            state_nx = ADDR;
                            is_rd_nx = 1'b0;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        addr_nx = shift_in;
                        if (is_rd_q) begin
                            tx_nx       = rd_val(shift_in, xdata_in, power_ctl);
                            xdata_rd_nx = (shift_in == ADDR_XDATA);
                            state_nx    = DATA_RD;
                        end else begin
                            state_nx = DATA_WR;
                        end
                    end
                end
                DATA_RD: begin
                    // The fall right after a reload belongs to the previous
                    // byte; shifting there would drop the fresh bit7.
                    if (sclk_fall && bit_cnt_q != 3'd0)
                        tx_nx = {tx_q[6:0], 1'b0};
                    if (byte_done) begin
                        addr_nx     = addr_inc;
                        tx_nx       = rd_val(addr_inc, xdata_in, power_ctl);
                        xdata_rd_nx = (addr_inc == ADDR_XDATA);
                    end
                end
                DATA_WR: begin
                    if (byte_done) begin
                        if (addr_q == ADDR_POWER_CTL)
                            power_ctl_nx = shift_in;
                        wr_strobe_nx = 1'b1;
                        wr_addr_nx   = addr_q;
                        wr_data_nx   = shift_in;
                        addr_nx      = addr_inc;
                    end
                end
                IGNORE: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            addr_q    <= 8'h00;
            tx_q      <= 8'h00;
            is_rd_q   <= 1'b0;
            power_ctl <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            xdata_rd  <= 1'b0;
        end else begin
            state_q   <= state_nx;
            bit_cnt_q <= bit_cnt_nx;
            shift_q   <= shift_nx;
            addr_q    <= addr_nx;
            tx_q      <= tx_nx;
            is_rd_q   <= is_rd_nx;
            power_ctl <= power_ctl_nx;
            wr_strobe <= wr_strobe_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
            xdata_rd  <= xdata_rd_nx;
        end
    end

    assign spi_miso = (state_q == DATA_RD) & tx_q[7];

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: table of SPI frames plus
// hand-written partial-byte, deselect-race and reset corner cases.
module tb_spi_accel_responder;

    localparam int H = 8;

    logic       clk_in = 1'b0;
    logic       nrst;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] xdata_in;
    logic [7:0] power_ctl;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       xdata_rd;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_xrd  = 0;
    logic [7:0] last_wa = 8'h00;
    logic [7:0] last_wd = 8'h00;

    spi_accel_responder dut (
        .clk_in   (clk_in),
        .nrst     (nrst),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .xdata_in (xdata_in),
        .power_ctl(power_ctl),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .xdata_rd (xdata_rd)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (nrst) begin
            if (wr_strobe) begin
                n_wr    = n_wr + 1;
                last_wa = wr_addr;
                last_wd = wr_data;
            end
            if (xdata_rd) n_xrd = n_xrd + 1;
        end
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  dat;
        logic [7:0]  xin;
        int          nb;
        logic [31:0] exp_rd;
        int          exp_wr;
        logic [7:0]  exp_wa;
        logic [7:0]  exp_wd;
        logic [7:0]  exp_pc;
        int          exp_xrd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (H) @(posedge clk_in);
        #1;
        r = spi_miso;
        spi_sclk = 1'b1;
        repeat (H) @(posedge clk_in);
        #1;
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_sel();
        spi_cs_n = 1'b0;
        repeat (H) @(posedge clk_in);
        #1;
    endtask

    task automatic cs_desel();
        repeat (H) @(posedge clk_in);
        #1;
        spi_cs_n = 1'b1;
        repeat (2 * H) @(posedge clk_in);
        #1;
    endtask

    task automatic do_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input int nb,
                            output logic [31:0] rx);
        logic [7:0] t;
        rx = '0;
        cs_sel();
        spi_byte(c, t);
        spi_byte(a, t);
        for (int i = 0; i < nb; i++) begin
            spi_byte(d, t);
            rx[31-8*i -: 8] = t;
        end
        cs_desel();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " miso"}, {31'd0, spi_miso}, 32'd0);
        chk({tag, " power_ctl"}, {24'd0, power_ctl}, 32'd0);
        chk({tag, " wr_strobe"}, {31'd0, wr_strobe}, 32'd0);
        chk({tag, " wr_addr"}, {24'd0, wr_addr}, 32'd0);
        chk({tag, " wr_data"}, {24'd0, wr_data}, 32'd0);
        chk({tag, " xdata_rd"}, {31'd0, xdata_rd}, 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        logic [31:0] rx;
        logic [7:0]  t;
        logic        r;
        logic [7:0]  pat;
        int          w0, x0;

        //       cmd    addr   dat    xin    nb exp_rd        wr wa     wd     pc     xrd
        vecs[0] = '{8'h0B, 8'h01, 8'hFF, 8'h00, 1, 32'h1D000000, 0, 8'h00, 8'h00, 8'h00, 0};
        vecs[1] = '{8'h0B, 8'h08, 8'hFF, 8'h80, 1, 32'h80000000, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[2] = '{8'h0B, 8'h00, 8'hFF, 8'h00, 4, 32'hAD1DF200, 0, 8'h00, 8'h00, 8'h00, 0};
        vecs[3] = '{8'h0B, 8'hFF, 8'hFF, 8'h00, 2, 32'h00AD0000, 0, 8'h00, 8'h00, 8'h00, 0};
        vecs[4] = '{8'h55, 8'h2D, 8'h02, 8'h00, 1, 32'h00000000, 0, 8'h00, 8'h00, 8'h00, 0};
        vecs[5] = '{8'h0A, 8'h2D, 8'h02, 8'h00, 1, 32'h00000000, 1, 8'h2D, 8'h02, 8'h02, 0};
        vecs[6] = '{8'h0A, 8'h10, 8'h33, 8'h00, 1, 32'h00000000, 1, 8'h10, 8'h33, 8'h02, 0};
        vecs[7] = '{8'h0B, 8'h2D, 8'hFF, 8'h00, 1, 32'h02000000, 0, 8'h00, 8'h00, 8'h02, 0};

        nrst     = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        xdata_in = 8'h00;
        repeat (5) @(posedge clk_in);
        #1;
        chk_reset_outs("reset");
        nrst = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;

        // Partial write byte is dropped on deselect.
        w0 = n_wr;
        cs_sel();
        spi_byte(8'h0A, t);
        spi_byte(8'h2D, t);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
        cs_desel();
        chk("partial pc", {24'd0, power_ctl}, 32'h00);
        chk("partial strobes", n_wr - w0, 0);
        do_frame(8'h0B, 8'h2D, 8'hFF, 1, rx);
        chk("partial readback", rx, 32'h00000000);

        for (int v = 0; v < 8; v++) begin
            xdata_in = vecs[v].xin;
            w0 = n_wr;
            x0 = n_xrd;
            do_frame(vecs[v].cmd, vecs[v].addr, vecs[v].dat,
                     vecs[v].nb, rx);
            for (int j = 0; j < vecs[v].nb; j++)
                chk($sformatf("v%0d rd byte%0d", v, j),
                    {24'd0, rx[31-8*j -: 8]},
                    {24'd0, vecs[v].exp_rd[31-8*j -: 8]});
            chk($sformatf("v%0d strobes", v), n_wr - w0, vecs[v].exp_wr);
            chk($sformatf("v%0d xdata_rd", v), n_xrd - x0, vecs[v].exp_xrd);
            chk($sformatf("v%0d power_ctl", v), {24'd0, power_ctl},
                {24'd0, vecs[v].exp_pc});
            chk($sformatf("v%0d idle miso", v), {31'd0, spi_miso}, 32'd0);
            if (vecs[v].exp_wr > 0) begin
                chk($sformatf("v%0d wr_addr", v), {24'd0, last_wa},
                    {24'd0, vecs[v].exp_wa});
                chk($sformatf("v%0d wr_data", v), {24'd0, last_wd},
                    {24'd0, vecs[v].exp_wd});
            end
        end
        xdata_in = 8'h00;

        // Deselect coinciding with the 8th rise of a write data byte.
        w0 = n_wr;
        pat = 8'h55;
        cs_sel();
        spi_byte(8'h0A, t);
        spi_byte(8'h2D, t);
        for (int i = 7; i >= 1; i--) spi_bit(pat[i], r);
        spi_mosi = pat[0];
        repeat (H) @(posedge clk_in);
        #1;
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        repeat (H) @(posedge clk_in);
        #1;
        spi_sclk = 1'b0;
        repeat (2 * H) @(posedge clk_in);
        #1;
        chk("race pc", {24'd0, power_ctl}, 32'h02);
        chk("race strobes", n_wr - w0, 0);

        // Reset in the middle of a read while miso drives a 1.
        cs_sel();
        spi_byte(8'h0B, t);
        spi_byte(8'h00, t);
        spi_bit(1'b1, r);
        spi_bit(1'b1, r);
        repeat (H) @(posedge clk_in);
        #1;
        chk("midread miso before reset", {31'd0, spi_miso}, 32'd1);
        nrst = 1'b0;
        #3;
        chk_reset_outs("midreset");
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        nrst = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        do_frame(8'h0B, 8'h00, 8'hFF, 1, rx);
        chk("post reset read", rx, 32'hAD000000);
        w0 = n_wr;
        do_frame(8'h0A, 8'h2D, 8'h05, 1, rx);
        chk("post reset pc", {24'd0, power_ctl}, 32'h05);
        chk("post reset strobes", n_wr - w0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
